run_length_classify: RTL and testbench
======================================

Name: run_length_classify

Overview:
Next-generation pulse-width detector for the PWM/OWT receive path. It measures each run of consecutive equal valid samples, up to 2^CNT_W-1 samples. Each completed run is classified against four runtime-programmable thresholds as SHORT, LONG or ERR. Classified symbols (level, code, length) are buffered in a small FIFO and drained via a valid/ready handshake to the downstream bit decoder.

Parameters:
CNT_W, 10, run-length counter and threshold width
FIFO_DEPTH, 4, symbol FIFO entries (power of 2, >=2)
FIFO_AW, $clog2(FIFO_DEPTH), FIFO pointer width (derived, do not override)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_en  input  1  block enable; low aborts the in-flight run
i_vld  input  1  sample strobe
i_vld_data  input  1  sample level
i_short_min  input  CNT_W  minimum SHORT run length
i_short_max  input  CNT_W  maximum SHORT run length
i_long_min  input  CNT_W  minimum LONG run length
i_long_max  input  CNT_W  maximum LONG run length
o_vld  output  1  FIFO head valid
i_rdy  input  1  downstream accepts head
o_level  output  1  level of the classified run
o_code  output  2  01=SHORT, 10=LONG, 11=ERR
o_len  output  CNT_W  measured run length (saturated)
o_fifo_cnt  output  FIFO_AW+1  occupied entries
o_ovf  output  1  sticky: a symbol was dropped because the FIFO was full
i_ovf_clr  input  1  clears o_ovf

Behaviour:
- Reset values: o_vld=0, o_level=0, o_code=0, o_len=0, o_fifo_cnt=0, o_ovf=0. Internal cnt=0, last_vld=0, last_data=0, ovr_rep=0.
- Run tracking (active only when i_en=1):
  - First sample (i_vld & ~last_vld): cnt<=1, last_data<=i_vld_data, last_vld<=1.
  - Same level: cnt<=cnt+1, saturating at all-ones (no wrap).
  - Level change (edge): the closing run (level=last_data, len=cnt) is classified. Then cnt<=1 and last_data<=i_vld_data.
  - Cycles with i_vld=0 hold all run state.
- Classification of a closing run (thresholds are sampled in the classifying cycle; SHORT is checked first):
  - short_min<=len<=short_max -> SHORT.
  - Else long_min<=len<=long_max -> LONG.
  - Else ERR.
- Overrun: while the run continues, if cnt+1 would exceed i_long_max and ovr_rep=0, push ERR with len=cnt+1 and set ovr_rep=1.
  - At the next edge of that run, no further symbol is pushed; ovr_rep clears at that edge.
- i_en=0: cnt<=0, last_vld<=0, ovr_rep<=0, no pushes. FIFO contents and handshake are unaffected.
- Latency: an edge or overrun sample at cycle t gives o_vld=1 at cycle t+1 when the FIFO was empty. Outputs are driven from the FIFO head register (no combinational path from i_vld).
- FIFO:
  - Pop when o_vld & i_rdy.
  - A push while full and not popping is dropped and sets o_ovf.
  - Push while full with a simultaneous pop is accepted (count unchanged).
  - Push and pop while empty: the entry is stored and o_vld rises the next cycle (no bypass).
  - Pointers wrap modulo FIFO_DEPTH.
- o_ovf: set has priority over i_ovf_clr in the same cycle.
- Overlapping threshold windows are legal (SHORT wins). Inverted windows (min>max) never match that class.
- Reset asserted mid-run or mid-drain clears everything asynchronously. The first sample after release starts a new run.

Test Plan:
- Thresholds 2/4/6/10. Stream 3x1, 8x0, 3x1 with i_rdy=1 -> symbols {1,SHORT,3} then {0,LONG,8}, each 1 cycle after its edge.
- Same thresholds, stream 1x1, 5x0, 1x1 -> {1,ERR,1}, {0,ERR,5}.
- 15 consecutive 1s then a 0 -> exactly one {1,ERR,11}, pushed on the 11th sample. No symbol at the edge; the next run starts at cnt=1.
- i_rdy=0, push 5 symbols into depth 4 -> o_fifo_cnt=4 and o_ovf=1. Then i_ovf_clr -> o_ovf=0, and draining returns the first 4 symbols in order.
- FIFO full, push and pop in the same cycle -> o_fifo_cnt stays 4, no overflow, and order is preserved.
- CNT_W=4, long_max=15, 20 equal samples -> len saturates at 15, cnt does not wrap, and the edge gives {x,LONG,15}. Separately, drop i_en mid-run -> no symbol, and the run restarts at 1.

Source files
------------

// File: rtl/run_length_classify.sv
// Run-length classifier for the PWM/OWT receive path.
// Measures runs of equal valid samples, classifies each closed run as
// SHORT/LONG/ERR against programmable windows, and queues the symbols
// in a small FIFO drained through a valid/ready handshake.
module run_length_classify #(
    parameter  int CNT_W      = 10,
    parameter  int FIFO_DEPTH = 4,
    localparam int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_vld,
    input  logic               i_vld_data,
    input  logic [CNT_W-1:0]   i_short_min,
    input  logic [CNT_W-1:0]   i_short_max,
    input  logic [CNT_W-1:0]   i_long_min,
    input  logic [CNT_W-1:0]   i_long_max,
    output logic               o_vld,
    input  logic               i_rdy,
    output logic               o_level,
    output logic [1:0]         o_code,
    output logic [CNT_W-1:0]   o_len,
    output logic [FIFO_AW:0]   o_fifo_cnt,
    output logic               o_ovf,
    input  logic               i_ovf_clr
);

    localparam int         SYM_W      = CNT_W + 3;
    localparam logic [1:0] CODE_SHORT = 2'b01;
    localparam logic [1:0] CODE_LONG  = 2'b10;
    localparam logic [1:0] CODE_ERR   = 2'b11;

    logic [CNT_W-1:0]   r_cnt;
    logic               r_last_vld;
    logic               r_last_data;
    logic               r_ovr_rep;

    logic [SYM_W-1:0]   r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_ovf;

    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_take;
    logic               w_same;
    logic               w_edge;
    logic               w_ovr_hit;
    logic               w_push;
    logic [1:0]         w_class;
    logic [SYM_W-1:0]   w_sym;
    logic               w_full;
    logic               w_pop;
    logic               w_wr;
    logic               w_drop;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    assign w_take = i_en & i_vld;
    assign w_same = r_last_vld & (i_vld_data == r_last_data);
    assign w_edge = r_last_vld & (i_vld_data != r_last_data);

    // Overrun compares the saturated next length, so a window reaching
    // all-ones never reports an overrun on a saturated run.
    assign w_ovr_hit = w_take & w_same & ~r_ovr_rep & (w_cnt_inc > i_long_max);
    assign w_push    = w_ovr_hit | (w_take & w_edge & ~r_ovr_rep);

    // Classify the closing run; SHORT window is checked first.
    always_comb begin
        w_class = CODE_ERR;
        if ((i_short_min <= r_cnt) && (r_cnt <= i_short_max)) begin
            w_class = CODE_SHORT;
        end else if ((i_long_min <= r_cnt) && (r_cnt <= i_long_max)) begin
            w_class = CODE_LONG;
        end
    end

    assign w_sym = w_ovr_hit ? {r_last_data, CODE_ERR, w_cnt_inc}
                             : {r_last_data, w_class, r_cnt};

    // Run tracking: start, extend or close the current run on each strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_last_vld  <= 1'b0;
            r_last_data <= 1'b0;
            r_ovr_rep   <= 1'b0;
        end else if (!i_en) begin
            r_cnt      <= '0;
            r_last_vld <= 1'b0;
            r_ovr_rep  <= 1'b0;
        end else if (i_vld) begin
            if (!r_last_vld) begin
                r_cnt       <= CNT_W'(1);
                r_last_data <= i_vld_data;
                r_last_vld  <= 1'b1;
                r_ovr_rep   <= 1'b0;
            end else if (w_same) begin
                r_cnt <= w_cnt_inc;
                if (w_ovr_hit) begin
                    r_ovr_rep <= 1'b1;
                end
            end else begin
                r_cnt       <= CNT_W'(1);
                r_last_data <= i_vld_data;
                r_ovr_rep   <= 1'b0;
            end
        end
    end

    assign w_full = (r_count == (FIFO_AW+1)'(FIFO_DEPTH));
    assign w_pop  = (r_count != '0) & i_rdy;
    assign w_wr   = w_push & (~w_full | w_pop);
    assign w_drop = w_push & w_full & ~w_pop;

    // Symbol storage; a full FIFO still accepts a push when the head leaves.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[r_wr_ptr] <= w_sym;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag; a drop in the same cycle beats the clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (i_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign o_vld      = (r_count != '0);
    assign o_level    = r_mem[r_rd_ptr][SYM_W-1];
    assign o_code     = r_mem[r_rd_ptr][SYM_W-2 -: 2];
    assign o_len      = r_mem[r_rd_ptr][CNT_W-1:0];
    assign o_fifo_cnt = r_count;
    assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_run_length_classify.sv
// Scoreboard bench for run_length_classify: a default-width instance (A)
// and a CNT_W=4 instance (B) for the saturation and enable-abort cases.
module tb_run_length_classify;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, vld, vd, rdy, ovf_clr, en_a, en_b;
    logic [9:0] a_smin, a_smax, a_lmin, a_lmax, a_len;
    logic       a_ovld, a_lvl, a_ovf;
    logic [1:0] a_code;
    logic [2:0] a_cnt;
    logic [3:0] b_smin, b_smax, b_lmin, b_lmax, b_len;
    logic       b_ovld, b_lvl, b_ovf;
    logic [1:0] b_code;
    logic [2:0] b_cnt;

    run_length_classify u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en_a), .i_vld(vld), .i_vld_data(vd),
        .i_short_min(a_smin), .i_short_max(a_smax), .i_long_min(a_lmin), .i_long_max(a_lmax),
        .o_vld(a_ovld), .i_rdy(rdy), .o_level(a_lvl), .o_code(a_code), .o_len(a_len),
        .o_fifo_cnt(a_cnt), .o_ovf(a_ovf), .i_ovf_clr(ovf_clr)
    );

    run_length_classify #(.CNT_W(4)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en_b), .i_vld(vld), .i_vld_data(vd),
        .i_short_min(b_smin), .i_short_max(b_smax), .i_long_min(b_lmin), .i_long_max(b_lmax),
        .o_vld(b_ovld), .i_rdy(rdy), .o_level(b_lvl), .o_code(b_code), .o_len(b_len),
        .o_fifo_cnt(b_cnt), .o_ovf(b_ovf), .i_ovf_clr(ovf_clr)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int lvl;
        int code;
        int len;
    } sym_t;

    sym_t qa[$];
    sym_t qb[$];

    task automatic exp_a(input int l, input int c, input int n);
        sym_t s;
        s = '{l, c, n};
        qa.push_back(s);
    endtask

    task automatic exp_b(input int l, input int c, input int n);
        sym_t s;
        s = '{l, c, n};
        qb.push_back(s);
    endtask

    // Compare each symbol that the handshake will transfer at the next edge.
    always @(negedge clk) begin
        sym_t s;
        if (rst_n && a_ovld && rdy) begin
            if (qa.size() == 0) begin
                check("a_unexpected", 1, 0);
            end else begin
                s = qa.pop_front();
                check("a_level", a_lvl, s.lvl);
                check("a_code", a_code, s.code);
                check("a_len", a_len, s.len);
            end
        end
    end

    always @(negedge clk) begin
        sym_t s;
        if (rst_n && b_ovld && rdy) begin
            if (qb.size() == 0) begin
                check("b_unexpected", 1, 0);
            end else begin
                s = qb.pop_front();
                check("b_level", b_lvl, s.lvl);
                check("b_code", b_code, s.code);
                check("b_len", b_len, s.len);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp(input bit d, input int n);
        for (int i = 0; i < n; i++) begin
            vld = 1'b1;
            vd  = d;
            cyc();
        end
    endtask

    task automatic endrun_a();
        vld  = 1'b0;
        en_a = 1'b0;
        cyc();
        en_a = 1'b1;
    endtask

    task automatic drain(input int n);
        rdy = 1'b1;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        rst_n = 1'b0; vld = 1'b0; vd = 1'b0; rdy = 1'b1; ovf_clr = 1'b0;
        en_a = 1'b0; en_b = 1'b0;
        a_smin = 10'd2; a_smax = 10'd4; a_lmin = 10'd6; a_lmax = 10'd10;
        b_smin = 4'd2;  b_smax = 4'd4;  b_lmin = 4'd5;  b_lmax = 4'd15;
        cyc(); cyc();
        check("rst_vld", a_ovld, 0);
        check("rst_level", a_lvl, 0);
        check("rst_code", a_code, 0);
        check("rst_len", a_len, 0);
        check("rst_cnt", a_cnt, 0);
        check("rst_ovf", a_ovf, 0);
        rst_n = 1'b1;
        en_a  = 1'b1;
        cyc();

        // Basic SHORT / LONG with one-cycle latency.
        exp_a(1, 1, 3);
        exp_a(0, 2, 8);
        smp(1, 3);
        check("t1_pre", a_ovld, 0);
        smp(0, 1);
        check("t1_lat", a_ovld, 1);
        smp(0, 7);
        check("t1_mid", a_ovld, 0);
        smp(1, 1);
        check("t1_lat2", a_ovld, 1);
        smp(1, 2);
        endrun_a();
        drain(4);
        check("t1_sb_empty", qa.size(), 0);

        // Runs outside both windows.
        exp_a(1, 3, 1);
        exp_a(0, 3, 5);
        smp(1, 1);
        smp(0, 5);
        smp(1, 1);
        endrun_a();
        drain(4);
        check("t2_sb_empty", qa.size(), 0);

        // Overrun: one ERR on the 11th sample, nothing at the edge.
        exp_a(1, 3, 11);
        exp_a(0, 1, 3);
        smp(1, 10);
        check("t3_pre", a_ovld, 0);
        smp(1, 1);
        check("t3_ovr", a_ovld, 1);
        smp(1, 4);
        smp(0, 1);
        check("t3_noedge", a_ovld, 0);
        smp(0, 2);
        smp(1, 1);
        endrun_a();
        drain(4);
        check("t3_sb_empty", qa.size(), 0);

        // Overflow: five symbols into four entries with the sink stalled.
        rdy = 1'b0;
        exp_a(1, 1, 3);
        exp_a(0, 1, 3);
        exp_a(1, 1, 3);
        exp_a(0, 1, 3);
        smp(1, 3); smp(0, 3); smp(1, 3); smp(0, 3); smp(1, 3);
        check("t4_no_ovf_yet", a_ovf, 0);
        smp(0, 1);
        endrun_a();
        check("t4_cnt", a_cnt, 4);
        check("t4_ovf", a_ovf, 1);
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        check("t4_ovf_clr", a_ovf, 0);
        check("t4_cnt_hold", a_cnt, 4);
        drain(6);
        check("t4_sb_empty", qa.size(), 0);
        check("t4_cnt_empty", a_cnt, 0);

        // Full FIFO with push and pop in the same cycle.
        rdy = 1'b0;
        exp_a(1, 1, 3);
        exp_a(0, 1, 3);
        exp_a(1, 1, 3);
        exp_a(0, 1, 3);
        exp_a(1, 1, 3);
        smp(1, 3); smp(0, 3); smp(1, 3); smp(0, 3); smp(1, 3);
        check("t5_full", a_cnt, 4);
        rdy = 1'b1;
        smp(0, 1);
        rdy = 1'b0;
        check("t5_cnt", a_cnt, 4);
        check("t5_ovf", a_ovf, 0);
        endrun_a();
        drain(6);
        check("t5_sb_empty", qa.size(), 0);

        // Narrow instance: saturation, then an enable drop mid-run.
        en_a = 1'b0;
        en_b = 1'b1;
        rdy  = 1'b1;
        exp_b(1, 2, 15);
        exp_b(0, 3, 1);
        exp_b(1, 1, 3);
        smp(1, 20);
        check("t6_no_ovr", b_ovld, 0);
        smp(0, 1);
        check("t6_sat_push", b_ovld, 1);
        smp(1, 5);
        en_b = 1'b0;
        cyc(); cyc();
        check("t6_abort", b_ovld, 0);
        en_b = 1'b1;
        smp(1, 3);
        smp(0, 1);
        vld  = 1'b0;
        en_b = 1'b0;
        drain(4);
        check("t6_sb_empty", qb.size(), 0);

        // Reset in the middle of a run with a symbol pending.
        en_a = 1'b1;
        rdy  = 1'b0;
        smp(1, 3);
        smp(0, 1);
        vld = 1'b0;
        check("t7_pending", a_cnt, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_cnt", a_cnt, 0);
        check("t7_rst_vld", a_ovld, 0);
        check("t7_rst_len", a_len, 0);
        cyc();
        rst_n = 1'b1;
        rdy   = 1'b1;
        cyc();
        exp_a(0, 1, 4);
        smp(0, 4);
        smp(1, 1);
        endrun_a();
        drain(4);
        check("t7_sb_empty", qa.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
